logicnet_input_packer: RTL and testbench
========================================

LOGICNET_INPUT_PACKER -- requirements
Module: logicnet_input_packer

Interface
REQ-001 SHALL have parameter NUM_FEATURES, default 16: number of features per frame, range 2..64.
REQ-002 SHALL have parameter IN_WIDTH, default 8: width of each unsigned raw feature.
REQ-003 SHALL have parameters THR1, THR2, THR3, defaults 64, 128, 192: ascending quantisation thresholds.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port s_data, input, IN_WIDTH: raw feature value.
REQ-007 SHALL have port s_valid, input, 1: s_data is valid.
REQ-008 SHALL have port s_last, input, 1: marks the final feature of a frame.
REQ-009 SHALL have port s_ready, output, 1: the block accepts a beat.
REQ-010 SHALL have port m_data, output, 2*NUM_FEATURES: packed 2-bit codes, feature i at bits [2i+1:2i], for the layer0 neuron inputs.
REQ-011 SHALL have port m_valid, output, 1: m_data holds a complete frame.
REQ-012 SHALL have port m_ready, input, 1: downstream accepts the frame.
REQ-013 SHALL have port m_err, output, 1: frame-length error flag, qualified by m_valid.

Function
REQ-014 SHALL quantise each accepted beat combinationally as code = (x>=THR1)+(x>=THR2)+(x>=THR3), giving a 2-bit result of 0..3.
REQ-015 SHALL accept a beat when s_valid && s_ready are both high; no beat is accepted otherwise.
REQ-016 SHALL implement FSM states COLLECT, HOLD and DROP, with reset state COLLECT.
REQ-017 SHALL assert s_ready in COLLECT and DROP, and deassert it in HOLD.
REQ-018 In COLLECT, SHALL write the code of an accepted beat into slot idx, where idx is a counter of width clog2(NUM_FEATURES), then increment idx.
REQ-019 In COLLECT, SHALL go to HOLD with m_err=0 when the accepted beat has idx==NUM_FEATURES-1 and s_last=1.
REQ-020 In COLLECT, SHALL go to HOLD with m_err=1 and unwritten slots set to 0 when an accepted beat has s_last=1 and idx<NUM_FEATURES-1 (short frame).
REQ-021 In COLLECT, SHALL emit the frame with m_err=1 and set a pending-drop flag when an accepted beat has idx==NUM_FEATURES-1 and s_last=0 (long frame).
REQ-022 SHALL assert m_valid in HOLD only, with latency of 1 cycle from acceptance of the closing beat.
REQ-023 SHALL hold m_data, m_valid and m_err stable while m_valid && !m_ready.
REQ-024 In HOLD, when m_ready=1, SHALL clear the frame buffer and idx to 0 and go to DROP if pending-drop is set, otherwise to COLLECT.
REQ-025 In DROP, SHALL discard accepted beats without storing them, and go to COLLECT and clear pending-drop on an accepted beat with s_last=1.
REQ-026 SHALL wrap idx to 0 only via the frame-close paths in REQ-019 to REQ-024, never by arithmetic overflow.
REQ-027 SHALL keep m_valid combinationally independent of m_ready, with no bubble beyond the single HOLD cycle when m_ready is already high.

Reset
REQ-028 On rst, SHALL asynchronously force state=COLLECT, idx=0, frame buffer=0, pending-drop=0, m_valid=0, m_err=0 and m_data=0.
REQ-029 On rst asserted mid-frame or in HOLD, SHALL lose any partial or held frame, with no emission after deassert.
REQ-030 After rst deasserts, SHALL have s_ready=1 in the first clock cycle.

Structure
REQ-031 SHALL place the state encoding (COLLECT, HOLD, DROP) and the default thresholds in shared package logicnet_pkg.
REQ-032 SHALL implement the threshold compare of REQ-014 as sub-module logicnet_quantizer, which is purely combinational with parameterised thresholds.
REQ-033 SHALL have a target RTL size of about 150-250 lines, with output registers driven directly from flops.

Verification
REQ-034 With NUM_FEATURES=4, sending beats 0, 64, 130, 255 (last on the 4th) SHALL give m_data=8'b11_10_01_00, m_err=0 and m_valid one cycle after the 4th beat.
REQ-035 Sending beats 63, 127, 191, 192 SHALL give codes 0, 1, 2, 3 (boundary inclusivity).
REQ-036 Holding m_ready=0 for 5 cycles SHALL keep m_data and m_valid constant with s_ready=0; a beat offered meanwhile SHALL not be consumed.
REQ-037 A short frame of 2 beats (200, 200, last) SHALL give m_data=8'b00_00_11_11 and m_err=1.
REQ-038 A long frame of 6 beats (last on the 6th) SHALL emit after the 4th beat with m_err=1, drop beats 5 and 6, and let the next frame pack correctly.
REQ-039 Asserting rst after 2 beats SHALL give no m_valid, and a following full frame SHALL pack from slot 0.

Source files
------------

// File: rtl/logicnet_pkg.sv
// Shared definitions for the LogicNet input packer.
// Holds FSM state encoding and default quantisation thresholds.
package logicnet_pkg;

   localparam logic [1:0] ST_COLLECT = 2'd0;
   localparam logic [1:0] ST_HOLD    = 2'd1;
   localparam logic [1:0] ST_DROP    = 2'd2;

   localparam int DEF_THR1 = 64;
   localparam int DEF_THR2 = 128;
   localparam int DEF_THR3 = 192;

endpackage

// File: rtl/logicnet_quantizer.sv
// Combinational 2-bit quantiser for one raw feature.
// Code is the number of thresholds the value reaches (inclusive).
module logicnet_quantizer #(
   parameter int W    = 8,
   parameter int THR1 = 64,
   parameter int THR2 = 128,
   parameter int THR3 = 192
) (
   input  logic [W-1:0] x,
   output logic [1:0]   code
);

   localparam logic [W-1:0] T1 = W'(THR1);
   localparam logic [W-1:0] T2 = W'(THR2);
   localparam logic [W-1:0] T3 = W'(THR3);

   assign code = 2'(x >= T1) + 2'(x >= T2) + 2'(x >= T3);

endmodule

// File: rtl/logicnet_input_packer.sv
// Packs a frame of quantised features into one wide word.
// Short and long frames are flagged; long-frame tails are dropped.
module logicnet_input_packer
   import logicnet_pkg::*;
#(
   parameter int NUM_FEATURES = 16,
   parameter int IN_WIDTH     = 8,
   parameter int THR1         = DEF_THR1,
   parameter int THR2         = DEF_THR2,
   parameter int THR3         = DEF_THR3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [IN_WIDTH-1:0]       s_data,
   input  logic                      s_valid,
   input  logic                      s_last,
   output logic                      s_ready,
   output logic [2*NUM_FEATURES-1:0] m_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic                      m_err
);

   localparam int IDX_W = $clog2(NUM_FEATURES);
   localparam int OUT_W = 2 * NUM_FEATURES;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEATURES - 1);

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [OUT_W-1:0] buf_q, buf_d;
   logic             pend_q, pend_d;
   logic             m_valid_q, m_valid_d;
   logic             m_err_q, m_err_d;
   logic [1:0]       code;
   logic             accept;
   logic             at_last;

   logicnet_quantizer #(
      .W    (IN_WIDTH),
      .THR1 (THR1),
      .THR2 (THR2),
      .THR3 (THR3)
   ) u_quant (
      .x    (s_data),
      .code (code)
   );

   assign s_ready = (state_q != ST_HOLD);
   assign accept  = s_valid && s_ready;
   assign at_last = (idx_q == IDX_LAST);
   assign m_data  = buf_q;
   assign m_valid = m_valid_q;
   assign m_err   = m_err_q;

   // Next-state: collect beats, hold the frame, or drop a long-frame tail
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      buf_d     = buf_q;
      pend_d    = pend_q;
      m_valid_d = m_valid_q;
      m_err_d   = m_err_q;
      case (state_q)
         ST_COLLECT: begin
            if (accept) begin
               buf_d[{idx_q, 1'b0} +: 2] = code;
               if (s_last || at_last) begin
                  state_d   = ST_HOLD;
                  m_valid_d = 1'b1;
                  m_err_d   = !(s_last && at_last);
                  pend_d    = !s_last;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_HOLD: begin
            if (m_ready) begin
               buf_d     = '0;
               idx_d     = '0;
               m_valid_d = 1'b0;
               m_err_d   = 1'b0;
               state_d   = pend_q ? ST_DROP : ST_COLLECT;
            end
         end
         ST_DROP: begin
            if (accept && s_last) begin
               state_d = ST_COLLECT;
               pend_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_COLLECT;
         end
      endcase
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_COLLECT;
         idx_q     <= '0;
         buf_q     <= '0;
         pend_q    <= 1'b0;
         m_valid_q <= 1'b0;
         m_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         buf_q     <= buf_d;
         pend_q    <= pend_d;
         m_valid_q <= m_valid_d;
         m_err_q   <= m_err_d;
      end
   end

endmodule

// File: tb/tb_logicnet_input_packer.sv
// Directed bench for logicnet_input_packer with NUM_FEATURES=4.
// Vector table for frames plus hand sequences for corner cases.
module tb_logicnet_input_packer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       m_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0][7:0] d;
      int              n;
      logic [7:0]      exp_data;
      logic            exp_err;
   } vec_t;

   vec_t vecs[8];

   logicnet_input_packer #(
      .NUM_FEATURES (4),
      .IN_WIDTH     (8),
      .THR1         (64),
      .THR2         (128),
      .THR3         (192)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_last  (s_last),
      .s_ready (s_ready),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_err   (m_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one beat and wait (bounded) until it is accepted.
   task automatic send_beat(input logic [7:0] d, input logic last);
      logic ok;
      ok      = 1'b0;
      s_data  = d;
      s_last  = last;
      s_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = s_ready;
         @(posedge clk);
      end
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk("beat_accept_timeout", {31'd0, ok}, 32'd1);
   endtask

   task automatic send_frame(input logic [3:0][7:0] d, input int n);
      for (int b = 0; b < n; b++) begin
         send_beat(d[b], b == n - 1);
         if (b != n - 1)
            chk("no_early_valid", {31'd0, m_valid}, 32'd0);
      end
   endtask

   logic [3:0][7:0] fr;
   logic [7:0]      held;

   initial begin
      rst     = 1'b1;
      s_data  = '0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;

      vecs[0] = '{d: {8'd255, 8'd130, 8'd64, 8'd0},   n: 4,
                  exp_data: 8'hE4, exp_err: 1'b0};
      vecs[1] = '{d: {8'd192, 8'd191, 8'd127, 8'd63}, n: 4,
                  exp_data: 8'hE4, exp_err: 1'b0};
      vecs[2] = '{d: {8'd10, 8'd100, 8'd150, 8'd250}, n: 4,
                  exp_data: 8'h1B, exp_err: 1'b0};
      vecs[3] = '{d: {8'd64, 8'd64, 8'd64, 8'd64},    n: 4,
                  exp_data: 8'h55, exp_err: 1'b0};
      vecs[4] = '{d: {8'd63, 8'd192, 8'd191, 8'd128}, n: 4,
                  exp_data: 8'h3A, exp_err: 1'b0};
      vecs[5] = '{d: {8'd0, 8'd0, 8'd200, 8'd200},    n: 2,
                  exp_data: 8'h0F, exp_err: 1'b1};
      vecs[6] = '{d: {8'd0, 8'd0, 8'd0, 8'd255},      n: 1,
                  exp_data: 8'h03, exp_err: 1'b1};
      vecs[7] = '{d: {8'd0, 8'd128, 8'd192, 8'd0},    n: 3,
                  exp_data: 8'h2C, exp_err: 1'b1};

      #1;
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_m_data",  {24'd0, m_data},  32'd0);
      chk("rst_m_err",   {31'd0, m_err},   32'd0);
      chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

      for (int i = 0; i < 8; i++) begin
         send_frame(vecs[i].d, vecs[i].n);
         chk($sformatf("vec%0d_valid", i), {31'd0, m_valid}, 32'd1);
         chk($sformatf("vec%0d_data", i), {24'd0, m_data},
             {24'd0, vecs[i].exp_data});
         chk($sformatf("vec%0d_err", i), {31'd0, m_err},
             {31'd0, vecs[i].exp_err});
         chk($sformatf("vec%0d_sready", i), {31'd0, s_ready}, 32'd0);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_release", i), {31'd0, m_valid}, 32'd0);
         chk($sformatf("vec%0d_clear", i), {24'd0, m_data}, 32'd0);
      end

      // Backpressure: frame held while a beat is offered
      m_ready = 1'b0;
      fr = {8'd0, 8'd64, 8'd128, 8'd255};
      send_frame(fr, 4);
      held = m_data;
      chk("bp_data", {24'd0, m_data}, 32'h1B);
      for (int c = 0; c < 5; c++) begin
         s_data  = 8'd255;
         s_last  = 1'b1;
         s_valid = 1'b1;
         @(posedge clk);
         #1;
         chk("bp_valid", {31'd0, m_valid}, 32'd1);
         chk("bp_stable", {24'd0, m_data}, {24'd0, held});
         chk("bp_sready", {31'd0, s_ready}, 32'd0);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release", {31'd0, m_valid}, 32'd0);
      fr = {8'd64, 8'd0, 8'd0, 8'd0};
      send_frame(fr, 4);
      chk("bp_next_data", {24'd0, m_data}, 32'h40);
      chk("bp_next_err", {31'd0, m_err}, 32'd0);
      @(posedge clk);
      #1;

      // Long frame: emit after 4th beat, drop 5th and 6th
      for (int b = 0; b < 4; b++) send_beat(8'd255, 1'b0);
      chk("long_valid", {31'd0, m_valid}, 32'd1);
      chk("long_err", {31'd0, m_err}, 32'd1);
      chk("long_data", {24'd0, m_data}, 32'hFF);
      send_beat(8'd0, 1'b0);
      chk("long_drop5", {31'd0, m_valid}, 32'd0);
      send_beat(8'd0, 1'b1);
      chk("long_drop6", {31'd0, m_valid}, 32'd0);
      fr = {8'd10, 8'd100, 8'd150, 8'd250};
      send_frame(fr, 4);
      chk("long_next_valid", {31'd0, m_valid}, 32'd1);
      chk("long_next_data", {24'd0, m_data}, 32'h1B);
      chk("long_next_err", {31'd0, m_err}, 32'd0);
      @(posedge clk);
      #1;

      // Reset mid-frame
      send_beat(8'd255, 1'b0);
      send_beat(8'd255, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, m_valid}, 32'd0);
      chk("midrst_data", {24'd0, m_data}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_sready", {31'd0, s_ready}, 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         chk("midrst_quiet", {31'd0, m_valid}, 32'd0);
      end
      fr = {8'd0, 8'd0, 8'd0, 8'd255};
      send_frame(fr, 4);
      chk("midrst_next_data", {24'd0, m_data}, 32'h03);
      chk("midrst_next_err", {31'd0, m_err}, 32'd0);
      @(posedge clk);
      #1;

      // Reset while holding a frame
      m_ready = 1'b0;
      fr = {8'd255, 8'd255, 8'd255, 8'd255};
      send_frame(fr, 4);
      chk("holdrst_pre", {31'd0, m_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("holdrst_valid", {31'd0, m_valid}, 32'd0);
      chk("holdrst_data", {24'd0, m_data}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_ready = 1'b1;
      chk("holdrst_sready", {31'd0, s_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("holdrst_quiet", {31'd0, m_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
